// File: rtl/music_tone_pkg.sv
// Shared types and constants for the note/song binary-to-BCD converters.
// Used by freq_bin_to_bcd (build option: BCD_SATURATE_EN) and bcd_add3.
package music_tone_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    localparam int BCD_W        = 4;
    localparam int BCD_MAX_DISP = 9999;

    // Number of decimal digits needed to hold 2**w-1 (bounded loop keeps it elaboration-friendly).
    function automatic int bcd_digits(input int w);
        longint v;
        int     n;
        v = (longint'(1) << w) - 1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v > 0) begin
                v = v / 10;
                n = n + 1;
            end
        end
        if (n == 0) n = 1;
        return n;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble adjust: digits of 5 or more get +3 before the shift.
module bcd_add3
    import music_tone_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    assign dout = (din >= BCD_W'(5)) ? din + BCD_W'(3) : din;

endmodule

// File: rtl/freq_bin_to_bcd.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Build option: define BCD_SATURATE_EN to clamp values above 9999 to 9999 and flag ovf.
module freq_bin_to_bcd
    import music_tone_pkg::*;
#(
    parameter int BIN_W = 14,
    parameter int NDIG  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic [3:0]       hund,
`ifdef BCD_SATURATE_EN
    output logic [3:0]       thou,
    output logic             ovf
`else
    output logic [3:0]       thou
`endif
);

    localparam int NSCR  = bcd_digits(BIN_W);
    localparam int SCR_W = NSCR * BCD_W;
    localparam int OUT_W = NDIG * BCD_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    conv_state_t        state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [SCR_W-1:0]   scr_q,   scr_d;
    logic [SCR_W-1:0]   scr_adj;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [OUT_W-1:0]   dig_q,   dig_d;
    logic               done_q,  done_d;
`ifdef BCD_SATURATE_EN
    logic               ovf_cap_q, ovf_cap_d;
    logic               ovf_q,     ovf_d;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NSCR; gi++) begin : g_adj
            bcd_add3 u_add3 (
                .din  (scr_q[gi*BCD_W +: BCD_W]),
                .dout (scr_adj[gi*BCD_W +: BCD_W])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        done_d  = 1'b0;
`ifdef BCD_SATURATE_EN
        ovf_cap_d = ovf_cap_q;
        ovf_d     = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = bin;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = SHIFT;
`ifdef BCD_SATURATE_EN
                    ovf_cap_d = (32'(bin) > 32'(BCD_MAX_DISP));
`endif
                end
            end
            SHIFT: begin
                // Adjust first, then shift the combined scratch:shift register.
                {scr_d, shift_d} = {scr_adj, shift_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
                dig_d   = scr_q[OUT_W-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef BCD_SATURATE_EN
                ovf_d = ovf_cap_q;
                if (ovf_cap_q) dig_d = {NDIG{4'd9}};
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            done_q  <= 1'b0;
`ifdef BCD_SATURATE_EN
            ovf_cap_q <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            done_q  <= done_d;
`ifdef BCD_SATURATE_EN
            ovf_cap_q <= ovf_cap_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign ones = dig_q[3:0];
    assign tens = dig_q[7:4];
    assign hund = dig_q[11:8];
    assign thou = dig_q[15:12];
`ifdef BCD_SATURATE_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_freq_bin_to_bcd.sv
// Scoreboard bench for freq_bin_to_bcd: directed cases plus randomized conversions
// checked against a decimal-arithmetic reference model.
module tb_freq_bin_to_bcd;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [3:0]  ones, tens, hund, thou;
`ifdef BCD_SATURATE_EN
    logic        ovf;
`endif

    freq_bin_to_bcd #(.BIN_W(14), .NDIG(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .ones  (ones),
        .tens  (tens),
        .hund  (hund),
`ifdef BCD_SATURATE_EN
        .thou  (thou),
        .ovf   (ovf)
`else
        .thou  (thou)
`endif
    );

    typedef struct {
        logic [15:0] dig;
        logic        ovf;
        int          due;
        int          bin;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_mis = 0;
    int          cyc   = 0;
    logic [15:0] held_dig  = '0;
    logic        held_ovf  = 1'b0;
    logic        prev_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] cur_digits();
        return {16'd0, thou, hund, tens, ones};
    endfunction

    function automatic logic cur_ovf();
`ifdef BCD_SATURATE_EN
        return ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: plain decimal arithmetic on the value, not a bit-serial algorithm.
    function automatic exp_t model(input int b);
        exp_t e;
        int   v;
`ifdef BCD_SATURATE_EN
        e.ovf = (b > 9999);
        v     = e.ovf ? 9999 : b;
`else
        e.ovf = 1'b0;
        v     = b % 10000;
`endif
        e.dig = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
        e.due = 0;
        e.bin = b;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse; otherwise outputs must hold.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            held_dig = '0;
            held_ovf = 1'b0;
            chk("reset_digits", cur_digits(), 32'd0);
            chk("reset_done", {31'd0, done}, 32'd0);
        end else if (done === 1'b1) begin
            chk("done_width", {31'd0, prev_done}, 32'd0);
            if (q.size() == 0) begin
                n_vec++;
                n_mis++;
                $display("FAIL unexpected_done: got digits %0h expected no done", cur_digits());
            end else begin
                mon_e = q.pop_front();
                chk("digits", cur_digits(), {16'd0, mon_e.dig});
                chk("latency", 32'(cyc), 32'(mon_e.due));
                chk("busy_at_done", {31'd0, busy}, 32'd0);
                chk("ovf", {31'd0, cur_ovf()}, {31'd0, mon_e.ovf});
                held_dig = mon_e.dig;
                held_ovf = mon_e.ovf;
                $display("conv bin=%0d -> %0h ovf=%0b cycle=%0d", mon_e.bin, cur_digits(), cur_ovf(), cyc);
            end
        end else begin
            chk("hold_digits", cur_digits(), {16'd0, held_dig});
            chk("hold_ovf", {31'd0, cur_ovf()}, {31'd0, held_ovf});
        end
        prev_done = done;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            n_vec++;
            n_mis++;
            $display("FAIL idle_timeout: got busy=%0b expected 0 within 100 cycles", busy);
        end
    endtask

    // Called at posedge+1; start is accepted on the following edge.
    task automatic convert(input int b, input bit hold);
        exp_t e;
        wait_idle();
        start = 1'b1;
        bin   = 14'(b);
        e     = model(b);
        e.due = cyc + 16;
        @(posedge clk);
        #1;
        q.push_back(e);
        if (hold) begin
            repeat (10) begin
                bin = 14'($urandom);
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int n;
        int b;
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        #3;
        chk("init_busy", {31'd0, busy}, 32'd0);
        chk("init_digits", cur_digits(), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        convert(0, 1'b0);
        convert(440, 1'b0);
        convert(9999, 1'b0);
        convert(1234, 1'b0);
        convert(5678, 1'b1);
        convert(12345, 1'b0);
        convert(100, 1'b0);
        convert(16383, 1'b0);
        convert(10000, 1'b0);

        // Abort a conversion of 8191 partway through.
        convert(8191, 1'b0);
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        void'(q.pop_back());
        #1;
        chk("abort_digits", cur_digits(), 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        convert(8191, 1'b0);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 5))
                0:       b = 9999;
                1:       b = 10000 + int'($urandom_range(0, 6383));
                default: b = int'($urandom_range(0, 16383));
            endcase
            convert(b, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) begin
                wait_idle();
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL drain: got %0d pending results expected 0", q.size());
        end
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
